// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo PWM with frame-boundary width latching and clamping (optional SERVO_SLEW_EN slew limit)
module servo_pwm_gen #(
  parameter int PERIOD    = 2_000_000,
  parameter int MIN_WIDTH = 50_000,
  parameter int MAX_WIDTH = 250_000,
  parameter int SLEW_STEP = 5_000,
  parameter int CNT_W     = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [17:0] width_in,
  output logic        pwm_out,
  output logic        frame_done,
  output logic        clamped,
  output logic [17:0] cur_width
);
  localparam int CW = CNT_W > 18 ? CNT_W : 18;
  if (PERIOD <= MAX_WIDTH || MAX_WIDTH >= 2**18 || MIN_WIDTH > MAX_WIDTH || (2**CNT_W) < PERIOD || SLEW_STEP < 1)
    $error("servo_pwm_gen: inconsistent parameters");
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [17:0] act, act_nxt, tgt;
  logic bnd, live;
  // frame boundary detect, clamped target, and next counter/width state
  always_comb begin
    bnd = cnt == CNT_W'(PERIOD - 1);
    live = enable && width_in != '0;
    tgt = !live ? '0 : width_in < 18'(MIN_WIDTH) ? 18'(MIN_WIDTH) : width_in > 18'(MAX_WIDTH) ? 18'(MAX_WIDTH) : width_in;
    clamped = bnd && live && tgt != width_in;
    frame_done = bnd;
    cnt_nxt = bnd ? '0 : cnt + CNT_W'(1);
`ifdef SERVO_SLEW_EN
    act_nxt = !bnd ? act : (tgt == '0 || act == '0) ? tgt :
              tgt > act ? (tgt - act > 18'(SLEW_STEP) ? act + 18'(SLEW_STEP) : tgt) :
                          (act - tgt > 18'(SLEW_STEP) ? act - 18'(SLEW_STEP) : tgt);
`else
    act_nxt = bnd ? tgt : act;
`endif
  end
  // state registers; pwm is driven from next-state so it lines up with cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      act <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      act <= act_nxt;
      pwm_out <= CW'(cnt_nxt) < CW'(act_nxt);
    end
  end
  assign cur_width = act;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed frame-level checks of servo_pwm_gen
module tb_servo_pwm_gen;
  localparam int P = 1000;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [17:0] width_in = '0, cur_width;
  logic pwm_out, frame_done, clamped;
  int vectors = 0, errs = 0;

  servo_pwm_gen #(.PERIOD(P), .MIN_WIDTH(50), .MAX_WIDTH(250), .SLEW_STEP(20), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .width_in(width_in),
    .pwm_out(pwm_out), .frame_done(frame_done), .clamped(clamped), .cur_width(cur_width)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // from a cnt==0 negedge, wait (bounded) for the boundary, counting pwm highs
  task automatic to_boundary(input string tag);
    int n = 0, hi = 0;
    for (int i = 0; i < 2 * P; i++) begin
      if (frame_done) break;
      if (pwm_out) hi++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, P - 1);
    chk({tag, "_hi"}, hi, 0);
  endtask

  // from a boundary negedge, observe one full frame; optionally change inputs at cnt==at
  task automatic frame(input string tag, input int at, input logic [17:0] nw, input logic ne,
                       input int exp_w, input int exp_clp);
    int hi = 0, run = 0, fdc = 0;
    bit brk = 0;
    logic clp = 1'b0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (!pwm_out) brk = 1;
      else if (!brk) run++;
      if (frame_done) fdc++;
      if (i == P - 1) begin
        chk({tag, "_fd_last"}, int'(frame_done), 1);
        clp = clamped;
      end
      if (i == at) begin
        width_in = nw;
        enable = ne;
      end
    end
    chk({tag, "_hi"}, hi, exp_w);
    chk({tag, "_run"}, run, exp_w);
    chk({tag, "_fdc"}, fdc, 1);
    chk({tag, "_clamped"}, int'(clp), exp_clp);
    chk({tag, "_cur"}, int'(cur_width), exp_w);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_clamped", int'(clamped), 0);
    chk("rst_cur", int'(cur_width), 0);
    rst = 1'b0;
    enable = 1'b1;
    width_in = 18'd240;
    to_boundary("f0");
    chk("f0_clamped", int'(clamped), 0);
`ifdef SERVO_SLEW_EN
    frame("s_f1", -1, 18'd240, 1'b1, 240, 0);
    frame("s_f2", 100, 18'd65, 1'b1, 240, 0);
    for (int k = 1; k <= 8; k++) frame("s_down", -1, 18'd65, 1'b1, 240 - 20 * k, 0);
    frame("s_last", -1, 18'd65, 1'b1, 65, 0);
    frame("s_hold", 100, 18'd0, 1'b1, 65, 0);
    frame("s_zero", 100, 18'd240, 1'b1, 0, 0);
    frame("s_jump", -1, 18'd240, 1'b1, 240, 0);
`else
    frame("f1", -1, 18'd240, 1'b1, 240, 0);
    frame("f2_mid", 100, 18'd65, 1'b1, 240, 0);
    frame("f3_hi_cmd", 100, 18'd300, 1'b1, 65, 1);
    frame("f4_lo_cmd", 100, 18'd10, 1'b1, 250, 1);
    frame("f5_zero_cmd", 100, 18'd0, 1'b1, 50, 0);
    frame("f6_nopulse", 100, 18'd240, 1'b1, 0, 0);
    frame("f7_en_drop", 100, 18'd240, 1'b0, 240, 0);
    frame("f8_disabled", 100, 18'd240, 1'b1, 0, 0);
    frame("f9", -1, 18'd240, 1'b1, 240, 0);
    repeat (121) @(negedge clk);
    chk("mid_pwm_hi", int'(pwm_out), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm", int'(pwm_out), 0);
    chk("mid_rst_cur", int'(cur_width), 0);
    chk("mid_rst_fd", int'(frame_done), 0);
    rst = 1'b0;
    to_boundary("after_rst");
    frame("f_recover", -1, 18'd240, 1'b1, 240, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream stage of the marble-dispense servo controller: consumes the 18-bit pulse-width command (clock cycles) and produces the physical servo PWM pin.
- Fixed-period frame (default 20 ms at 100 MHz); width latched only at frame boundaries, so no runt or truncated pulses.
- Clamps commands to a safe servo range and reports frame timing back to the controller.

Parameters:
- PERIOD, 2_000_000, frame length in clk cycles; must exceed MAX_WIDTH.
- MIN_WIDTH, 50_000, smallest nonzero pulse width in cycles.
- MAX_WIDTH, 250_000, largest pulse width in cycles; must be < 2^18.
- SLEW_STEP, 5_000, maximum width change per frame; used only with SERVO_SLEW_EN.
- CNT_W, 21, frame counter width; 2^CNT_W >= PERIOD.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  drive pulses when high; sampled only at frame boundary.
- width_in  input  18  commanded pulse width in cycles; 0 means no pulse.
- pwm_out  output  1  registered servo PWM pin.
- frame_done  output  1  one-cycle strobe on the last cycle of each frame.
- clamped  output  1  one-cycle strobe, coincident with frame_done, when the loaded width was clamped.
- cur_width  output  18  width currently being driven (active register).

Behaviour:
- Reset (rst=1 at a clk edge):
  - Frame counter cnt=0, active width=0, pwm_out=0, frame_done=0, clamped=0, cur_width=0.
  - Reset mid-pulse drives pwm_out low on the next cycle.
  - The first frame after reset starts with cnt=0 and produces no pulse, because active width is 0.
- Frame counter:
  - cnt counts 0..PERIOD-1 and wraps to 0.
  - The boundary cycle is cnt==PERIOD-1; frame_done=1 on exactly that cycle.
- Width load (boundary cycle only):
  - enable=0 or width_in=0 → next active width = 0.
  - Otherwise next active width = clamp(width_in):
    - below MIN_WIDTH → MIN_WIDTH;
    - above MAX_WIDTH → MAX_WIDTH;
    - else unchanged.
  - clamped=1 on the boundary cycle iff the clamp altered a nonzero enabled width_in.
  - width_in and enable changes off the boundary have no effect until the next boundary.
- Pulse timing:
  - pwm_out is high for exactly W consecutive cycles, where W is the active width. It is high on the cycles where cnt==0..W-1 of the frame, then low for the rest of the frame.
  - pwm_out is registered and computed from next-state values, so there is no added latency relative to cnt.
  - W=0 → pwm_out stays low for the whole frame.
- cur_width:
  - Equals the active width.
  - Updates on the cycle cnt becomes 0, i.e. the edge after the boundary.
- Simultaneous rst and boundary: rst wins; nothing loads.
- Width arithmetic:
  - All comparisons unsigned.
  - cnt is compared against the zero-extended 18-bit width; no overflow is possible because MAX_WIDTH < PERIOD.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined — at each boundary the target is computed as above, then:
  - target=0 or active=0 → load target directly;
  - else active moves toward target by min(|target-active|, SLEW_STEP);
  - clamped is unaffected by slewing.
- Undefined — the target loads directly every boundary; SLEW_STEP is unused.

Test Plan:
All directed tests override PERIOD=1000, MIN_WIDTH=50, MAX_WIDTH=250, CNT_W=10.
- Basic pulse: rst 2 cycles, then enable=1, width_in=240.
  - Frame 0 has no pulse; frame_done pulses every 1000 cycles.
  - From frame 1 on, pwm_out is high exactly 240 cycles starting at cnt=0; cur_width=240.
- Mid-frame change: during frame 2, change width_in 240→65 at cnt=100.
  - Frame 2 still pulses 240 cycles; frame 3 pulses 65.
- Clamp: width_in=300 → next frame 250 cycles, clamped=1 on that boundary. width_in=10 → 50 cycles, clamped=1. width_in=0 → no pulse, clamped=0.
- Enable drop: enable→0 at cnt=100 while pwm_out is high.
  - Current pulse completes its full 240 cycles; the next frame has no pulse; cur_width=0.
- Reset mid-pulse: rst at cnt=120 with W=240.
  - pwm_out=0 the next cycle; cnt restarts at 0; the following frame has no pulse.
- Slew (SERVO_SLEW_EN, SLEW_STEP=20): W=240 steady, then width_in=65.
  - Successive frames pulse 220, 200, …, 80, then 65, then stay at 65.
  - From W=0, width_in=240 jumps directly to 240.
